// File: rtl/writeback_queue_pkg.sv
// rtl/writeback_queue_pkg.sv - shared widths and entry type for the writeback queue
package writeback_queue_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry;

endpackage

// File: rtl/writeback_queue_fwd_match.sv
// rtl/writeback_queue_fwd_match.sv - youngest-match forwarding search (built only with WBQ_FORWARD_EN)
module wbq_fwd_match
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  // index 0 is the oldest pending entry, DEPTH-1 the youngest slot
  input  wb_entry [DEPTH-1:0]   i_entries,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [REG_ADDR_W-1:0] i_addr,
  output logic                  o_hit,
  output logic [DATA_W-1:0]     o_data
);

`ifdef WBQ_FORWARD_EN
  // scan oldest to youngest so a younger match overrides an older one
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_valid[k] && (i_entries[k].rd == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[k].data;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_entries, i_valid, i_addr};
  assign o_hit    = 1'b0;
  assign o_data   = '0;
`endif

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - dual-producer register writeback FIFO with forwarding (WBQ_FORWARD_EN)
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] RD,
  output logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] RS,
  input  logic [REG_ADDR_W-1:0] RT,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit,
  output logic [DATA_W-1:0]     fwd_rs_data,
  output logic [DATA_W-1:0]     fwd_rt_data,
  output logic                  stall,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry           r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_pop;
  logic [CNT_W-1:0]  w_free;
  logic              w_mem_acc;
  logic              w_alu_acc;
  logic              w_drop;
  logic [PTR_W-1:0]  w_alu_slot;
  wb_entry [DEPTH-1:0] w_ord;
  logic [DEPTH-1:0]  w_ord_vld;

  // the register file always accepts, so the head drains whenever anything is pending;
  // the slot freed by that pop is available to this edge's pushes, mem taking it first
  always_comb begin
    w_pop      = (r_count != '0);
    w_free     = DEPTH_C - r_count + CNT_W'(w_pop);
    w_mem_acc  = mem_valid && (w_free != '0);
    w_alu_acc  = alu_valid && (w_free > CNT_W'(w_mem_acc));
    w_drop     = (mem_valid && !w_mem_acc) || (alu_valid && !w_alu_acc);
    w_alu_slot = r_tail + PTR_W'(w_mem_acc);
  end

  // pointer, occupancy and sticky overflow state
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_head     <= r_head + PTR_W'(w_pop);
      r_tail     <= r_tail + PTR_W'(w_mem_acc) + PTR_W'(w_alu_acc);
      r_count    <= r_count + CNT_W'(w_mem_acc) + CNT_W'(w_alu_acc) - CNT_W'(w_pop);
      r_overflow <= r_overflow | w_drop;
    end
  end

  // entry storage; stale contents are harmless because occupancy gates every read
  always_ff @(posedge Clock) begin
    if (w_mem_acc) r_mem[r_tail]     <= '{rd: mem_rd, data: mem_data};
    if (w_alu_acc) r_mem[w_alu_slot] <= '{rd: alu_rd, data: alu_data};
  end

  // present the queue oldest-first so the search can resolve age by position
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_ord[k]     = r_mem[r_head + PTR_W'(k)];
      w_ord_vld[k] = (CNT_W'(k) < r_count);
    end
  end

  assign RegWrite  = w_pop;
  assign RD        = w_pop ? r_mem[r_head].rd   : '0;
  assign WriteData = w_pop ? r_mem[r_head].data : '0;
  assign stall     = (r_count > CNT_W'(DEPTH - 2));
  assign overflow  = r_overflow;

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
    .i_entries (w_ord),
    .i_valid   (w_ord_vld),
    .i_addr    (RS),
    .o_hit     (fwd_rs_hit),
    .o_data    (fwd_rs_data)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
    .i_entries (w_ord),
    .i_valid   (w_ord_vld),
    .i_addr    (RT),
    .o_hit     (fwd_rt_hit),
    .o_data    (fwd_rt_data)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue against a queue-based reference
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [2:0]  alu_rd = '0, mem_rd = '0, RS = '0, RT = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic        RegWrite, fwd_rs_hit, fwd_rt_hit, stall, overflow;
  logic [2:0]  RD;
  logic [15:0] WriteData, fwd_rs_data, fwd_rt_data;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .RS(RS), .RT(RT),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .stall(stall), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  wb_entry model_q[$];   // reference contents, oldest at index 0
  wb_entry exp_q[$];     // scoreboard of writes the register file must see, in order
  bit      model_ovf = 1'b0;
  int      n_vec = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // youngest pending entry for a register, if any
  task automatic fwd_ref(input logic [2:0] a, output bit hit, output logic [15:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].rd == a) begin
        hit = 1'b1;
        d   = model_q[i].data;
        break;
      end
    end
  endtask

  // what one rising edge does: drain one, then admit mem then alu into whatever space remains
  task automatic model_edge(input bit mv, input wb_entry me, input bit av, input wb_entry ae);
    int free;
    if (Reset) return;
    if (model_q.size() != 0) void'(model_q.pop_front());
    free = DEPTH - model_q.size();
    if (mv) begin
      if (free > 0) begin model_q.push_back(me); exp_q.push_back(me); free--; end
      else model_ovf = 1'b1;
    end
    if (av) begin
      if (free > 0) begin model_q.push_back(ae); exp_q.push_back(ae); free--; end
      else model_ovf = 1'b1;
    end
  endtask

  task automatic cycle(input bit mv, input logic [2:0] mrd, input logic [15:0] md,
                       input bit av, input logic [2:0] ard, input logic [15:0] ad,
                       input logic [2:0] rs, input logic [2:0] rt);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    RS = rs; RT = rt;
    n_vec++;
    @(posedge Clock);
    model_edge(mv, '{rd: mrd, data: md}, av, '{rd: ard, data: ad});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 3'd0, 3'd0);
  endtask

  // assert reset between edges and check that pending work vanishes at once
  task automatic async_reset();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_stall", stall, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rs_hit", fwd_rs_hit, 0);
    model_q.delete();
    exp_q.delete();
    model_ovf = 1'b0;
    idle(2);
    Reset = 1'b0;
  endtask

  // monitor: every cycle compare the write port, flags and forwarding against the scoreboard
  always @(negedge Clock) begin
    wb_entry     e;
    bit          h;
    logic [15:0] d;
    if (RegWrite) begin
      if (exp_q.size() == 0) chk("spurious_write", RegWrite, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_rd", RD, e.rd);
        chk("wr_data", WriteData, e.data);
      end
    end else begin
      chk("write_missing", exp_q.size(), 0);
      chk("idle_rd", RD, 0);
      chk("idle_data", WriteData, 0);
    end
    chk("stall", stall, (model_q.size() > DEPTH - 2) ? 1 : 0);
    chk("overflow", overflow, model_ovf);
    fwd_ref(RS, h, d);
    chk("rs_hit", fwd_rs_hit, FWD ? h : 0);
    chk("rs_data", fwd_rs_data, FWD ? d : 0);
    fwd_ref(RT, h, d);
    chk("rt_hit", fwd_rt_hit, FWD ? h : 0);
    chk("rt_data", fwd_rt_data, FWD ? d : 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    idle(2);

    // single alu write into an empty queue
    cycle(0, 0, 0, 1, 3'd3, 16'h1234, 3'd0, 3'd0);
    idle(3);

    // simultaneous producers: mem drains first
    cycle(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 3'd0, 3'd0);
    idle(3);

    // two pending writes to r5: youngest forwards, r6 misses
    cycle(1, 3'd5, 16'h0001, 1, 3'd5, 16'h0002, 3'd0, 3'd0);
    cycle(0, 0, 0, 0, 0, 0, 3'd5, 3'd6);
    idle(3);

    // r0 is an ordinary register
    cycle(1, 3'd0, 16'hBEEF, 0, 0, 0, 3'd0, 3'd0);
    cycle(0, 0, 0, 0, 0, 0, 3'd0, 3'd0);
    idle(2);

    // saturate with dual pushes: stall, then drop and sticky overflow
    for (int i = 0; i < 4; i++)
      cycle(1, 3'(i), 16'(16'h1000 + i), 1, 3'(i + 4), 16'(16'h2000 + i), 3'(i), 3'(i + 4));
    chk("ovf_set", overflow, 1);
    idle(6);
    chk("ovf_sticky", overflow, 1);
    async_reset();
    idle(2);

    // reset while three entries are pending
    cycle(1, 3'd7, 16'h7777, 1, 3'd6, 16'h6666, 3'd0, 3'd0);
    cycle(1, 3'd5, 16'h5151, 1, 3'd4, 16'h4444, 3'd0, 3'd0);
    async_reset();
    idle(4);

    // randomized traffic with periodic resets
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) < 55, 3'($urandom_range(0, 7)), 16'($urandom),
            $urandom_range(0, 99) < 55, 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (n % 130 == 129) async_reset();
    end
    idle(DEPTH + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
